// File: rtl/spi_arbiter.sv
// Two-requester SPI bus arbiter with per-requester chip select and a shared byte engine.
// Latency: cs_n one cycle after req, gnt CS_SETUP_CLKS cycles later, spi_start one cycle after byte_start.
// Backpressure: requesters hold req for the whole transaction; bytes wait on spi_done indefinitely.
module spi_arbiter #(
   parameter int unsigned CS_SETUP_CLKS = 2,
   parameter int unsigned CS_HOLD_CLKS  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   input  logic [1:0]  byte_start,
   input  logic [15:0] tx_data,
   output logic [1:0]  byte_done,
   output logic [7:0]  rx_data,
   output logic [1:0]  cs_n,
   output logic        spi_start,
   output logic [7:0]  spi_data_in,
   input  logic        spi_done,
   input  logic [7:0]  spi_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      READY,
      BUSY,
      CS_HOLD
   } state_t;

   // Counters run from LOAD down to zero, so a LOAD of N-1 spends N cycles in the state.
   localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP_CLKS - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD_CLKS - 1);

   state_t     state, state_nxt;
   logic       own, own_nxt;
   logic       last, last_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] rx_nxt;
   logic [7:0] sdi_nxt;
   logic       start_nxt;
   logic [1:0] done_nxt;
   logic       win;
   logic [1:0] own_sel;
   logic       cs_active;

   // State and datapath registers; reset releases the bus immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         own         <= 1'b0;
         last        <= 1'b1;
         cnt         <= 8'h00;
         rx_data     <= 8'h00;
         spi_data_in <= 8'h00;
         spi_start   <= 1'b0;
         byte_done   <= 2'b00;
      end else begin
         state       <= state_nxt;
         own         <= own_nxt;
         last        <= last_nxt;
         cnt         <= cnt_nxt;
         rx_data     <= rx_nxt;
         spi_data_in <= sdi_nxt;
         spi_start   <= start_nxt;
         byte_done   <= done_nxt;
      end
   end

   // Next-state, arbitration, counter and byte-transfer decisions.
   always_comb begin
      state_nxt = state;
      own_nxt   = own;
      last_nxt  = last;
      cnt_nxt   = cnt;
      rx_nxt    = rx_data;
      sdi_nxt   = spi_data_in;
      start_nxt = 1'b0;
      done_nxt  = 2'b00;
      win       = 1'b0;
      case (state)
         IDLE: begin
            // Round-robin on a tie; stale spi_done is ignored here.
            if (|req) begin
               win       = (req == 2'b11) ? ~last : req[1];
               own_nxt   = win;
               last_nxt  = win;
               cnt_nxt   = SETUP_LOAD;
               state_nxt = CS_SETUP;
            end
         end
         CS_SETUP: begin
            // Setup is never aborted; a dropped req releases from READY.
            if (cnt == 8'h00) state_nxt = READY;
            else              cnt_nxt   = cnt - 8'h01;
         end
         READY: begin
            // Release wins over a simultaneous byte request.
            if (!req[own]) begin
               cnt_nxt   = HOLD_LOAD;
               state_nxt = CS_HOLD;
            end else if (byte_start[own]) begin
               sdi_nxt   = own ? tx_data[15:8] : tx_data[7:0];
               start_nxt = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // A byte in flight always completes, even if req has dropped.
            if (spi_done) begin
               rx_nxt   = spi_data_out;
               done_nxt = own ? 2'b10 : 2'b01;
               if (req[own]) begin
                  state_nxt = READY;
               end else begin
                  cnt_nxt   = HOLD_LOAD;
                  state_nxt = CS_HOLD;
               end
            end
         end
         CS_HOLD: begin
            if (cnt == 8'h00) state_nxt = IDLE;
            else              cnt_nxt   = cnt - 8'h01;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Chip select and grant decode straight from state so reset clears them without a clock.
   always_comb begin
      own_sel   = own ? 2'b10 : 2'b01;
      cs_active = (state == CS_SETUP) || (state == READY) ||
                  (state == BUSY)     || (state == CS_HOLD);
      cs_n      = cs_active ? ~own_sel : 2'b11;
      gnt       = ((state == READY) || (state == BUSY)) ? own_sel : 2'b00;
   end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter CS_SETUP_CLKS, default 2, meaning clk cycles cs_n is low before gnt asserts (legal range 1..255).
REQ-002 The block SHALL have parameter CS_HOLD_CLKS, default 2, meaning clk cycles cs_n stays low after gnt drops (legal range 1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
REQ-004 The block SHALL have these requester-side ports:
- req  in  2  per-requester bus request, level; held high for the whole transaction
- gnt  out  2  per-requester grant, one-hot or zero
- byte_start  in  2  per-requester one-cycle byte request
- tx_data  in  16  transmit bytes; requester i uses bits [8i+7:8i]
- byte_done  out  2  per-requester one-cycle byte-complete pulse
- rx_data  out  8  last received byte, shared
- cs_n  out  2  per-requester SPI chip select, active low
REQ-005 The block SHALL have these engine-side ports:
- spi_start  out  1  byte-engine start pulse
- spi_data_in  out  8  byte to the engine
- spi_done  in  1  engine transfer complete
- spi_data_out  in  8  byte from the engine

Function
REQ-006 The block SHALL implement states IDLE, CS_SETUP, READY, BUSY and CS_HOLD, with owner register own (1 bit) and last-granted register last (1 bit).
REQ-007 In IDLE, the block SHALL arbitrate on the first cycle any req bit is high.
- Single request: grant that requester.
- Both high: grant the requester not equal to last (round-robin).
- On arbitration, load own and last with the winner and go to CS_SETUP.
REQ-008 On entry to CS_SETUP, the block SHALL drive cs_n[own] low and count CS_SETUP_CLKS cycles, then go to READY with gnt[own] high.
REQ-009 The block SHALL assert gnt[own] only in READY and BUSY.
REQ-010 In READY, byte_start[own] high SHALL cause the following on the next cycle:
- spi_data_in holds tx_data byte own;
- spi_start is high for exactly one cycle;
- state is BUSY.
REQ-011 In BUSY, the block SHALL hold spi_data_in stable, keep spi_start low after its pulse, and wait for spi_done.
REQ-012 On spi_done high in BUSY, the block SHALL, on the next cycle:
- load rx_data from spi_data_out;
- pulse byte_done[own] for exactly one cycle;
- return to READY.
REQ-013 byte_start from a non-owner, or in any state other than READY, SHALL be ignored with no side effects.
REQ-014 When req[own] is low in READY, the block SHALL go to CS_HOLD with gnt low on the next cycle.
REQ-015 When req[own] is low in BUSY, the block SHALL finish the byte (REQ-012) and then go to CS_HOLD instead of READY. byte_done SHALL still pulse.
REQ-016 In CS_HOLD, the block SHALL keep cs_n[own] low for CS_HOLD_CLKS cycles, then drive it high and enter IDLE.
REQ-017 IDLE SHALL last at least one cycle with both cs_n bits high before the next CS_SETUP, giving a minimum one-cycle CS deassertion between transactions.
REQ-018 At most one cs_n bit and one gnt bit SHALL be active at any time.
REQ-019 A requester's req falling in CS_SETUP SHALL not abort setup; the block SHALL enter READY and immediately release per REQ-014. gnt SHALL pulse for one cycle.
REQ-020 The setup/hold counter SHALL be 8 bits, reload on state entry, and never wrap.

Reset
REQ-021 While reset_n is low, the block SHALL drive asynchronously:
- state to IDLE, own to 0 and last to 1, so requester 0 wins the first tie;
- gnt, byte_done and spi_start to 0;
- cs_n to 2'b11;
- rx_data and spi_data_in to 8'h00;
- counter to 0.
REQ-022 Reset asserted mid-transfer SHALL immediately release cs_n and gnt. The engine is reset separately, and after reset the block SHALL ignore any stale spi_done seen in IDLE.

Verification
REQ-023 Single-requester transaction: req[0]=1 -> cs_n[0] low 1 cycle later, gnt[0] high after 2 more cycles. Then byte_start[0] with tx byte 8'hA5 and engine model echoing 8'h3C -> spi_start one pulse with spi_data_in=8'hA5, then byte_done[0] pulse with rx_data=8'h3C.
REQ-024 Tie and round-robin: req=2'b11 from reset -> requester 0 granted first. After req[0] drops -> CS_HOLD 2 cycles, 1 cycle with cs_n=2'b11, then requester 1 granted.
REQ-025 Three back-to-back bytes from requester 1 (8'h01, 8'h02, 8'h03) -> cs_n[1] held low throughout, three byte_done[1] pulses, rx_data matching each echo.
REQ-026 req[0] dropped while BUSY -> byte completes, byte_done[0] pulses, then CS_HOLD. byte_start[1] during this sequence -> no spi_start.
REQ-027 reset_n pulsed low during BUSY -> cs_n=2'b11 and gnt=0 within the same cycle. A late spi_done after reset -> no byte_done, state stays IDLE.
